// File: rtl/mmio_uart_ctrl.sv
// MEM-stage MMIO slave: 8N1 UART, cycle counter and retired-instruction counter.
// Define MMIO_RX_FIFO_EN to replace the single-byte RX holding register with an RX FIFO.
module mmio_uart_ctrl #(
  parameter int unsigned CPU_CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE      = 115200,
  parameter int unsigned RX_FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic        en,
  input  logic        we,
  input  logic        inst_retire,
  input  logic        serial_in,
  output logic        serial_out,
  output logic [31:0] dout
);

  localparam int unsigned BIT_T  = CPU_CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_T = BIT_T / 2;
  localparam int unsigned BCW    = $clog2(BIT_T);

  localparam logic [7:0] A_CTRL = 8'h00;
  localparam logic [7:0] A_RXD  = 8'h04;
  localparam logic [7:0] A_TXD  = 8'h08;
  localparam logic [7:0] A_CYC  = 8'h10;
  localparam logic [7:0] A_INST = 8'h14;
  localparam logic [7:0] A_CRST = 8'h18;

  localparam logic [0:0] TX_IDLE  = 1'b0;
  localparam logic [0:0] TX_SHIFT = 1'b1;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  logic [31:0]    cyc_q, cyc_d, inst_q, inst_d, dout_q, dout_d;
  logic [0:0]     tx_state_q, tx_state_d;
  logic [9:0]     tx_shift_q, tx_shift_d;
  logic [3:0]     tx_bit_q, tx_bit_d;
  logic [BCW-1:0] tx_baud_q, tx_baud_d;
  logic           serial_out_q, serial_out_d;
  logic [1:0]     rx_sync_q, rx_sync_d;
  logic           rx_prev_q, rx_prev_d;
  logic [1:0]     rx_state_q, rx_state_d;
  logic [2:0]     rx_bit_q, rx_bit_d;
  logic [BCW-1:0] rx_baud_q, rx_baud_d;
  logic [7:0]     rx_shift_q, rx_shift_d;
  logic           overrun_q, overrun_d;
  logic           rx_push, rx_pop, rx_valid, rd_acc, wr_acc, rx_line;
  logic [7:0]     rx_head, ofs;
  logic           unused_bits;

  assign ofs         = addr[7:0];
  assign rd_acc      = en && !we;
  assign wr_acc      = en && we;
  assign rx_line     = rx_sync_q[1];
  assign rx_pop      = rd_acc && (ofs == A_RXD) && rx_valid;
  assign serial_out  = serial_out_q;
  assign dout        = dout_q;
  assign unused_bits = ^{addr[31:8], din[31:8]};

`ifdef MMIO_RX_FIFO_EN
  localparam int unsigned PW = $clog2(RX_FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          push_ok;

  assign rx_valid = (cnt_q != '0);
  assign rx_head  = fifo_mem[rd_ptr_q];

  // A pop in the same cycle frees a slot, so a full FIFO still accepts then.
  always_comb begin
    overrun_d = overrun_q;
    push_ok   = rx_push && ((cnt_q != CW'(RX_FIFO_DEPTH)) || rx_pop);
    if (rd_acc && (ofs == A_CTRL)) overrun_d = 1'b0;
    if (rx_push && !push_ok) overrun_d = 1'b1;
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(rx_pop);
    cnt_d    = cnt_q + CW'(push_ok) - CW'(rx_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= rx_shift_q;
  end
`else
  logic [7:0] rx_buf_q, rx_buf_d;
  logic       rx_full_q, rx_full_d;

  assign rx_valid = rx_full_q;
  assign rx_head  = rx_buf_q;

  // Single holding byte: a push only lands if the slot is free or being popped.
  always_comb begin
    rx_buf_d  = rx_buf_q;
    rx_full_d = rx_full_q;
    overrun_d = overrun_q;
    if (rd_acc && (ofs == A_CTRL)) overrun_d = 1'b0;
    if (rx_pop) rx_full_d = 1'b0;
    if (rx_push) begin
      if (rx_full_q && !rx_pop) begin
        overrun_d = 1'b1;
      end else begin
        rx_buf_d  = rx_shift_q;
        rx_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_buf_q  <= '0;
      rx_full_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rx_buf_q  <= rx_buf_d;
      rx_full_q <= rx_full_d;
      overrun_q <= overrun_d;
    end
  end
`endif

  // Next-state for counters, read port, TX and RX FSMs.
  always_comb begin
    cyc_d        = cyc_q + 32'd1;
    inst_d       = inst_q + 32'(inst_retire);
    dout_d       = dout_q;
    tx_state_d   = tx_state_q;
    tx_shift_d   = tx_shift_q;
    tx_bit_d     = tx_bit_q;
    tx_baud_d    = tx_baud_q;
    rx_sync_d    = {rx_sync_q[0], serial_in};
    rx_prev_d    = rx_line;
    rx_state_d   = rx_state_q;
    rx_bit_d     = rx_bit_q;
    rx_baud_d    = rx_baud_q;
    rx_shift_d   = rx_shift_q;
    rx_push      = 1'b0;

    if (wr_acc && (ofs == A_CRST)) begin
      cyc_d  = '0;
      inst_d = '0;
    end

    if (rd_acc) begin
      case (ofs)
        A_CTRL:  dout_d = {29'b0, overrun_q, rx_valid, tx_state_q == TX_IDLE};
        A_RXD:   dout_d = {24'b0, rx_valid ? rx_head : 8'h00};
        A_CYC:   dout_d = cyc_q;
        A_INST:  dout_d = inst_q;
        default: dout_d = '0;
      endcase
    end

    case (tx_state_q)
      TX_IDLE: begin
        if (wr_acc && (ofs == A_TXD)) begin
          tx_state_d = TX_SHIFT;
          tx_shift_d = {1'b1, din[7:0], 1'b0};
          tx_bit_d   = '0;
          tx_baud_d  = '0;
        end
      end
      default: begin
        if (tx_baud_q == BCW'(BIT_T - 1)) begin
          tx_baud_d = '0;
          if (tx_bit_q == 4'd9) begin
            tx_state_d = TX_IDLE;
          end else begin
            tx_shift_d = {1'b1, tx_shift_q[9:1]};
            tx_bit_d   = tx_bit_q + 4'd1;
          end
        end else begin
          tx_baud_d = tx_baud_q + BCW'(1);
        end
      end
    endcase
    serial_out_d = (tx_state_d == TX_SHIFT) ? tx_shift_d[0] : 1'b1;

    // Start bit is checked at half a bit; later samples land mid-bit.
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_line) begin
          rx_state_d = RX_START;
          rx_baud_d  = '0;
        end
      end
      RX_START: begin
        if (rx_baud_q == BCW'(HALF_T - 1)) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_line ? RX_IDLE : RX_DATA;
        end else begin
          rx_baud_d = rx_baud_q + BCW'(1);
        end
      end
      RX_DATA: begin
        if (rx_baud_q == BCW'(BIT_T - 1)) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_baud_d = rx_baud_q + BCW'(1);
        end
      end
      default: begin
        if (rx_baud_q == BCW'(BIT_T - 1)) begin
          rx_baud_d  = '0;
          rx_push    = rx_line;
          rx_state_d = RX_IDLE;
        end else begin
          rx_baud_d = rx_baud_q + BCW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q        <= '0;
      inst_q       <= '0;
      dout_q       <= '0;
      tx_state_q   <= TX_IDLE;
      tx_shift_q   <= '1;
      tx_bit_q     <= '0;
      tx_baud_q    <= '0;
      serial_out_q <= 1'b1;
      rx_sync_q    <= 2'b11;
      rx_prev_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_bit_q     <= '0;
      rx_baud_q    <= '0;
      rx_shift_q   <= '0;
    end else begin
      cyc_q        <= cyc_d;
      inst_q       <= inst_d;
      dout_q       <= dout_d;
      tx_state_q   <= tx_state_d;
      tx_shift_q   <= tx_shift_d;
      tx_bit_q     <= tx_bit_d;
      tx_baud_q    <= tx_baud_d;
      serial_out_q <= serial_out_d;
      rx_sync_q    <= rx_sync_d;
      rx_prev_q    <= rx_prev_d;
      rx_state_q   <= rx_state_d;
      rx_bit_q     <= rx_bit_d;
      rx_baud_q    <= rx_baud_d;
      rx_shift_q   <= rx_shift_d;
    end
  end

endmodule
